// File: rtl/cache_pkg.sv
// Shared constants and types for the cache port arbiter.
package cache_pkg;

  localparam int unsigned NREQ            = 8;
  localparam int unsigned SELW            = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] sel_to_onehot(logic [SELW-1:0] s);
    return NREQ'(1) << s;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Request/grant bundle between the requester bank and the cache port arbiter.
interface cache_port_arbiter_if;
  import cache_pkg::*;

  logic [NREQ-1:0] req;
  logic            done;
  logic [SELW-1:0] sel;
  logic [NREQ-1:0] gnt;
  logic            start;
  logic            busy;
  logic            timeout_err;

  modport master (
    input  req,
    input  done,
    output sel,
    output gnt,
    output start,
    output busy,
    output timeout_err
  );

  modport slave (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  start,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner pick: rotate requests so ptr sits at bit 0, then take the lowest set bit.
module rr_pick
  import cache_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SELW-1:0]   off;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    found = |rot;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    // Offset is relative to ptr; 3-bit add wraps back to an absolute index.
    idx = ptr + off;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter for the shared cache port: one-hot grant, mux select, start pulse.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_port_arbiter_if.master bus
);

  arb_state_e      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            terr_q, terr_d;

  logic [NREQ-1:0] cand;
  logic [SELW-1:0] scan_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_found;
  logic            tmo_hit;
  logic            release_w;
  logic            grant_new;

  // Masking the current owner keeps it from being re-granted on its own done.
  assign cand     = bus.req & ~gnt_q;
  assign scan_ptr = (state_q == ARB_BUSY) ? sel_q + SELW'(1) : ptr_q;

  rr_pick u_pick (
    .req   (cand),
    .ptr   (scan_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_w = (state_q == ARB_BUSY) && (bus.done || tmo_hit);
  assign grant_new = pick_found && ((state_q == ARB_IDLE) || release_w);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts completed busy cycles; the TIMEOUT-th one ends in a forced release.
  assign tmo_hit = (state_q == ARB_BUSY) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_new) begin
      cnt_d = '0;
    end else if (state_q == ARB_BUSY) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_found) state_d = ARB_BUSY;
      ARB_BUSY: if (release_w && !pick_found) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    start_d = 1'b0;
    busy_d  = (state_d == ARB_BUSY);
    ptr_d   = ptr_q;
    terr_d  = tmo_hit && !bus.done;
    if (grant_new) begin
      sel_d   = pick_idx;
      gnt_d   = sel_to_onehot(pick_idx);
      start_d = 1'b1;
    end else if (release_w) begin
      gnt_d = '0;
    end
    if (release_w) begin
      ptr_d = sel_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.gnt         = gnt_q;
  assign bus.start       = start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

  gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
  gnt_matches_sel: assert property (@(posedge clk) disable iff (reset) busy_q |-> gnt_q[sel_q]);

endmodule
